rx_serial_7e1: RTL and testbench

- UART receiver for 7E1 frames at 115200 baud on a 50 MHz clock.
- Frame format: 1 start bit, 7 data bits LSB-first, even parity, 1 stop bit.
- It is the receiving end of the serial link driven by `spilling`'s `saida_serial`. It decodes the 7-bit ASCII categories/distances the main design transmits.
- Used as a loopback checker in the top-level and as a building block for a future host-side command input.

---
 rtl/serial_7e1_pkg.sv | 26 ++
 rtl/rx_serial_7e1_contador_baud.sv | 63 ++++++
 rtl/rx_serial_7e1.sv | 188 ++++++++++++++++++
 tb/tb_rx_serial_7e1.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_7e1_pkg.sv
// Shared definitions for the 7E1 serial link, used by both the receiver and the transmitter.
package serial_7e1_pkg;

   // Clock cycles per bit: 50 MHz / 115200 baud, rounded.
   localparam int DIVISOR_PADRAO = 434;

   // Data bits per frame (7-bit ASCII).
   localparam int LARGURA_DADOS = 7;

   // Receiver state codes, also exported on the debug port.
   typedef enum logic [3:0] {
      INICIAL        = 4'd0,
      VALIDA_INICIO  = 4'd1,
      RECEBE         = 4'd2,
      PARIDADE       = 4'd3,
      PARADA         = 4'd4,
      FINAL          = 4'd5,
      ESPERA_REPOUSO = 4'd6
   } estado_t;

   // Even-parity bit for a data word: the bit that makes the total count of ones even.
   function automatic logic paridade_par(input logic [LARGURA_DADOS-1:0] dados);
      return ^dados;
   endfunction

endpackage

// File: rtl/rx_serial_7e1_contador_baud.sv
// Baud-rate counter: counts 0..DIVISOR-1 and flags the bit boundary (tick) and the
// half-bit point (meio). Both flags are registered and are high during the cycle whose
// closing edge lands exactly DIVISOR (tick) or DIVISOR/2 (meio) edges after the count
// restarted from zero.
module contador_baud
   import serial_7e1_pkg::*;
#(
   parameter int DIVISOR = DIVISOR_PADRAO
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic tick,
   output logic meio
);

   localparam int         HALF     = DIVISOR / 2;
   localparam logic [8:0] CNT_MAX  = 9'(DIVISOR - 1);
   localparam logic [8:0] CNT_MEIO = 9'(HALF - 1);

   logic [8:0] cnt_q;
   logic [8:0] cnt_d;
   logic       tick_q;
   logic       tick_d;
   logic       meio_q;
   logic       meio_d;

   // Next count: clear on zera, otherwise advance and wrap at the end of a bit period.
   always_comb begin
      cnt_d = cnt_q;
      if (zera) begin
         cnt_d = 9'd0;
      end else if (conta) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = 9'd0;
         end else begin
            cnt_d = cnt_q + 9'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
      tick_d = (cnt_d == CNT_MAX);
      meio_d = (cnt_d == CNT_MEIO);
   end

   // Count and flag registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q  <= 9'd0;
         tick_q <= 1'b0;
         meio_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         meio_q <= meio_d;
      end
   end

   assign tick = tick_q;
   assign meio = meio_q;

endmodule

// File: rtl/rx_serial_7e1.sv
// 7E1 UART receiver (1 start, 7 data LSB-first, even parity, 1 stop) with a two-flop
// input synchronizer, mid-bit sampling and a guard state that keeps a stuck-low line
// from retriggering frames.
module rx_serial_7e1
   import serial_7e1_pkg::*;
#(
   parameter int DIVISOR = DIVISOR_PADRAO
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     dado_serial,
   output logic [LARGURA_DADOS-1:0] dados_ascii,
   output logic                     pronto,
   output logic                     erro_paridade,
   output logic                     erro_parada,
   output logic [3:0]               db_estado
);

   localparam logic [2:0] ULTIMO_BIT = 3'(LARGURA_DADOS - 1);

   logic                     rx_meta_q;
   logic                     rx_sync_q;
   logic                     rx_s;

   estado_t                  estado_q;
   estado_t                  estado_d;
   logic [LARGURA_DADOS-1:0] shift_q;
   logic [LARGURA_DADOS-1:0] shift_d;
   logic [2:0]               bit_cnt_q;
   logic [2:0]               bit_cnt_d;
   logic [LARGURA_DADOS-1:0] dados_q;
   logic [LARGURA_DADOS-1:0] dados_d;
   logic                     pronto_q;
   logic                     pronto_d;
   logic                     erro_paridade_q;
   logic                     erro_paridade_d;
   logic                     erro_parada_q;
   logic                     erro_parada_d;

   logic                     zera_s;
   logic                     tick_s;
   logic                     meio_s;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= dado_serial;
         rx_sync_q <= rx_meta_q;
      end
   end

   assign rx_s = rx_sync_q;

   // The counter is held at zero while the line idles, so the first low cycle seen in
   // INICIAL starts the count and every later sample lands mid-bit.
   contador_baud #(
      .DIVISOR (DIVISOR)
   ) u_contador_baud (
      .clock (clock),
      .reset (reset),
      .zera  (zera_s),
      .conta (1'b1),
      .tick  (tick_s),
      .meio  (meio_s)
   );

   // Frame decoding: next state, shift register, error flags and output updates.
   always_comb begin
      estado_d        = estado_q;
      shift_d         = shift_q;
      bit_cnt_d       = bit_cnt_q;
      dados_d         = dados_q;
      pronto_d        = 1'b0;
      erro_paridade_d = erro_paridade_q;
      erro_parada_d   = erro_parada_q;
      zera_s          = 1'b0;
      case (estado_q)
         INICIAL: begin
            zera_s = rx_s;
            if (!rx_s) begin
               estado_d = VALIDA_INICIO;
            end else begin
               estado_d = INICIAL;
            end
         end
         VALIDA_INICIO: begin
            if (meio_s) begin
               zera_s = 1'b1;
               if (rx_s) begin
                  // Line went back high before mid start bit: a glitch, not a frame.
                  estado_d = INICIAL;
               end else begin
                  erro_paridade_d = 1'b0;
                  erro_parada_d   = 1'b0;
                  shift_d         = '0;
                  bit_cnt_d       = 3'd0;
                  estado_d        = RECEBE;
               end
            end else begin
               estado_d = VALIDA_INICIO;
            end
         end
         RECEBE: begin
            if (tick_s) begin
               shift_d = {rx_s, shift_q[LARGURA_DADOS-1:1]};
               if (bit_cnt_q == ULTIMO_BIT) begin
                  bit_cnt_d = 3'd0;
                  estado_d  = PARIDADE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  estado_d  = RECEBE;
               end
            end else begin
               estado_d = RECEBE;
            end
         end
         PARIDADE: begin
            if (tick_s) begin
               erro_paridade_d = paridade_par(shift_q) ^ rx_s;
               estado_d        = PARADA;
            end else begin
               estado_d = PARIDADE;
            end
         end
         PARADA: begin
            if (tick_s) begin
               erro_parada_d = ~rx_s;
               estado_d      = FINAL;
            end else begin
               estado_d = PARADA;
            end
         end
         FINAL: begin
            zera_s   = 1'b1;
            pronto_d = 1'b1;
            dados_d  = shift_q;
            if (erro_parada_q) begin
               estado_d = ESPERA_REPOUSO;
            end else begin
               estado_d = INICIAL;
            end
         end
         ESPERA_REPOUSO: begin
            zera_s = 1'b1;
            if (rx_s) begin
               estado_d = INICIAL;
            end else begin
               estado_d = ESPERA_REPOUSO;
            end
         end
         default: begin
            zera_s   = 1'b1;
            estado_d = INICIAL;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q        <= INICIAL;
         shift_q         <= '0;
         bit_cnt_q       <= 3'd0;
         dados_q         <= '0;
         pronto_q        <= 1'b0;
         erro_paridade_q <= 1'b0;
         erro_parada_q   <= 1'b0;
      end else begin
         estado_q        <= estado_d;
         shift_q         <= shift_d;
         bit_cnt_q       <= bit_cnt_d;
         dados_q         <= dados_d;
         pronto_q        <= pronto_d;
         erro_paridade_q <= erro_paridade_d;
         erro_parada_q   <= erro_parada_d;
      end
   end

   assign dados_ascii   = dados_q;
   assign pronto        = pronto_q;
   assign erro_paridade = erro_paridade_q;
   assign erro_parada   = erro_parada_q;
   assign db_estado     = estado_q;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Bench for rx_serial_7e1: directed frames plus random frames, checked against a
// frame-level reference (expected completion time, data and error flags per frame).
module tb_rx_serial_7e1;

   localparam int DIV  = 434;
   localparam int LAT  = 2 + DIV / 2 + 9 * DIV + 1;   // raw start edge -> pronto

   logic       clock = 1'b0;
   logic       reset;
   logic       dado_serial;
   logic [6:0] dados_ascii;
   logic       pronto;
   logic       erro_paridade;
   logic       erro_parada;
   logic [3:0] db_estado;

   typedef struct {
      int unsigned cyc;
      logic [6:0]  d;
      logic        ep;
      logic        es;
   } ev_t;

   ev_t         obs_q[$];
   ev_t         exp_q[$];
   int unsigned cyc = 0;
   logic        pronto_prev = 1'b0;
   int          wide_pulses = 0;
   int          n_assert = 0;
   int          n_fail = 0;
   logic [6:0]  last_d = 7'd0;
   logic        last_ep = 1'b0;
   logic        last_es = 1'b0;

   rx_serial_7e1 dut (
      .clock         (clock),
      .reset         (reset),
      .dado_serial   (dado_serial),
      .dados_ascii   (dados_ascii),
      .pronto        (pronto),
      .erro_paridade (erro_paridade),
      .erro_parada   (erro_parada),
      .db_estado     (db_estado)
   );

   always #10 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Record every pronto cycle with the outputs seen alongside it.
   always @(negedge clock) begin
      if (pronto === 1'b1) begin
         if (pronto_prev === 1'b1) wide_pulses <= wide_pulses + 1;
         obs_q.push_back('{cyc, dados_ascii, erro_paridade, erro_parada});
      end
      pronto_prev <= pronto;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Drive one full frame; the reference entry is computed from the frame's bits.
   task automatic send_frame(input logic [6:0] d, input logic par, input logic stp);
      logic [9:0] bits;
      ev_t        e;
      bits   = {stp, par, d, 1'b0};
      e.cyc  = cyc + LAT;
      e.d    = d;
      e.ep   = ($countones({par, d}) % 2) != 0;
      e.es   = (stp == 1'b0);
      exp_q.push_back(e);
      for (int i = 0; i < 10; i++) begin
         dado_serial = bits[i];
         wait_cycles(DIV);
      end
   endtask

   task automatic check_events(input string tag);
      ev_t e;
      ev_t o;
      check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         check({tag, "_cycle"}, o.cyc, e.cyc);
         check({tag, "_data"}, 32'(o.d), 32'(e.d));
         check({tag, "_erro_paridade"}, 32'(o.ep), 32'(e.ep));
         check({tag, "_erro_parada"}, 32'(o.es), 32'(e.es));
         last_d  = e.d;
         last_ep = e.ep;
         last_es = e.es;
      end
      exp_q.delete();
      obs_q.delete();
      check({tag, "_hold_data"}, 32'(dados_ascii), 32'(last_d));
      check({tag, "_hold_paridade"}, 32'(erro_paridade), 32'(last_ep));
      check({tag, "_hold_parada"}, 32'(erro_parada), 32'(last_es));
   endtask

   initial begin
      logic [6:0] d;
      logic       bad;
      reset       = 1'b0;
      dado_serial = 1'b1;
      #5;
      check("rst_dados", 32'(dados_ascii), 32'd0);
      check("rst_pronto", 32'(pronto), 32'd0);
      check("rst_paridade", 32'(erro_paridade), 32'd0);
      check("rst_parada", 32'(erro_parada), 32'd0);
      check("rst_estado", 32'(db_estado), 32'd0);
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      wait_cycles(20);

      // 'A', good frame
      send_frame(7'h41, 1'b0, 1'b1);
      wait_cycles(50);
      check_events("frame_A");

      // '7' then '0' with no idle between frames
      send_frame(7'h37, 1'b1, 1'b1);
      send_frame(7'h30, 1'b0, 1'b1);
      wait_cycles(50);
      check_events("b2b");

      // parity bit wrong
      send_frame(7'h41, 1'b1, 1'b1);
      wait_cycles(50);
      check_events("par_err");

      // stop bit low, line held low, then released
      send_frame(7'h41, 1'b0, 1'b0);
      wait_cycles(2000);
      check("stop_err_wait_state", 32'(db_estado), 32'd6);
      dado_serial = 1'b1;
      wait_cycles(200);
      check("stop_err_idle_state", 32'(db_estado), 32'd0);
      check_events("stop_err");
      send_frame(7'h41, 1'b0, 1'b1);
      wait_cycles(50);
      check_events("after_stop_err");

      // short low glitch on an idle line
      dado_serial = 1'b0;
      wait_cycles(100);
      dado_serial = 1'b1;
      wait_cycles(60);
      check("glitch_validating", 32'(db_estado), 32'd1);
      wait_cycles(1000);
      check("glitch_state", 32'(db_estado), 32'd0);
      check_events("glitch");

      // reset pulse during data bit 3 of 0x55
      d = 7'h55;
      dado_serial = 1'b0;
      wait_cycles(DIV);
      for (int i = 0; i < 3; i++) begin
         dado_serial = d[i];
         wait_cycles(DIV);
      end
      dado_serial = d[3];
      wait_cycles(200);
      reset = 1'b0;
      #1;
      check("midrst_dados", 32'(dados_ascii), 32'd0);
      check("midrst_pronto", 32'(pronto), 32'd0);
      check("midrst_paridade", 32'(erro_paridade), 32'd0);
      check("midrst_parada", 32'(erro_parada), 32'd0);
      check("midrst_estado", 32'(db_estado), 32'd0);
      last_d      = 7'd0;
      last_ep     = 1'b0;
      last_es     = 1'b0;
      dado_serial = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      reset = 1'b1;
      wait_cycles(5000);
      check_events("rst_abort");
      send_frame(7'h55, 1'b0, 1'b1);
      wait_cycles(50);
      check_events("after_rst");

      // random frames, occasional parity errors, random idle gaps (possibly none)
      for (int k = 0; k < 6; k++) begin
         d   = 7'($urandom_range(0, 127));
         bad = ($urandom_range(0, 3) == 0);
         send_frame(d, (^d) ^ bad, 1'b1);
         wait_cycles(int'($urandom_range(0, 40)));
      end
      wait_cycles(50);
      check_events("random");

      check("pronto_width", 32'(wide_pulses), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
